// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable interval sequencer. A small table of
// terminal values drives an up-counter through up to `steps` consecutive
// intervals, pulsing step_tc at the end of each interval and done at the
// end of the last one.
//
// Control semantics (there is no valid/ready pair on this block):
//   start - level, sampled every rising edge; accepted only in IDLE with
//           abort low, ignored whenever busy is high.
//   abort - level, sampled every rising edge; in ARM or RUN it returns the
//           block to IDLE on that edge and suppresses any pulse that would
//           otherwise have been produced on the same edge.
//   hold  - level; in RUN it freezes count, step index and limit.
// All outputs are registers; nothing combinational reaches a port.
module counter_sequencer #(
  parameter int size  = 4,
  parameter int steps = 4,
  parameter int idx_w = 2
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cfg_we,
  input  logic [idx_w-1:0] cfg_addr,
  input  logic [size-1:0]  cfg_data,
  input  logic [idx_w-1:0] last_step,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  output logic             busy,
  output logic [idx_w-1:0] step_idx,
  output logic [size-1:0]  count,
  output logic             step_tc,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  // Terminal-value table; survives aborts, only reset clears it.
  logic [size-1:0]  tbl [steps];

  // Limit of the step in progress and the final step index of this run.
  logic [size-1:0]  limit;
  logic [size-1:0]  limit_n;
  logic [idx_w-1:0] last_idx;
  logic [idx_w-1:0] last_idx_n;

  logic [idx_w-1:0] idx_n;
  logic [size-1:0]  count_n;
  logic             busy_n;
  logic             step_tc_n;
  logic             done_n;

  // Index of the step following the current one; wraps naturally because
  // steps is a power of two.
  logic [idx_w-1:0] idx_inc;
  assign idx_inc = step_idx + idx_w'(1);

  // Current FSM state exported for checkers.
  assign dbg_state = state;

  // Table writes are only honoured while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (r) begin
      for (int i = 0; i < steps; i++) begin
        tbl[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_n    = state;
    count_n    = count;
    idx_n      = step_idx;
    limit_n    = limit;
    last_idx_n = last_idx;
    step_tc_n  = 1'b0;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n    = ARM;
          last_idx_n = last_step;
          idx_n      = '0;
          count_n    = '0;
          limit_n    = tbl[0];
        end
      end

      ARM: begin
        count_n = '0;
        if (abort) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          state_n = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          // Abort beats a step terminating on the same edge: no pulses.
          state_n = IDLE;
          count_n = '0;
          idx_n   = '0;
        end else if (!hold) begin
          if (count != limit) begin
            count_n = count + size'(1);
          end else begin
            count_n   = '0;
            step_tc_n = 1'b1;
            if (step_idx != last_idx) begin
              idx_n   = idx_inc;
              limit_n = tbl[idx_inc];
            end else begin
              done_n  = 1'b1;
              idx_n   = '0;
              state_n = IDLE;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
        count_n = '0;
        idx_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (r) begin
      state    <= IDLE;
      count    <= '0;
      step_idx <= '0;
      limit    <= '0;
      last_idx <= '0;
      busy     <= 1'b0;
      step_tc  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      step_idx <= idx_n;
      limit    <= limit_n;
      last_idx <= last_idx_n;
      busy     <= busy_n;
      step_tc  <= step_tc_n;
      done     <= done_n;
    end
  end

endmodule
